alu_issue_stage: RTL

- Decode and issue stage directly upstream of the ALU.
- Accepts 32-bit instruction words over a valid/ready handshake and splits them into the ALU control fields (Opcode, Cond, S, SR_Cont, SR_Bit, Immediate).
- Reads operands from an internal 32x32 register file and presents them to the ALU from a registered output stage.
- Accepts the ALU result back through a writeback port; a per-register scoreboard stalls RAW/WAW hazards.

---
 rtl/alu_issue_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the ALU: splits instruction fields, reads operands from a
// 32-entry register file and stalls on RAW/WAW hazards via a per-register pending scoreboard.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_opcode,
  output logic [3:0]        alu_cond,
  output logic              alu_s,
  output logic [2:0]        alu_sr_cont,
  output logic [4:0]        alu_sr_bit,
  output logic [15:0]       alu_imm,
  output logic [4:0]        out_rd,
  output logic              out_wr
);

  logic [3:0]        dec_opcode;
  logic [4:0]        dec_rd, dec_rn, dec_rm;
  logic              dec_writer;
  logic [DATA_W-1:0] rn_val, rm_val;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d, pend_eff, wb_onehot;

  logic              hazard, accept;
  logic              out_valid_q, out_wr_q;
  logic [31:0]       out_instr_q;
  logic [DATA_W-1:0] in1_q, in2_q;

  assign dec_opcode = in_instr[27:24];
  assign dec_rd     = in_instr[22:18];
  assign dec_rn     = in_instr[17:13];
  assign dec_rm     = in_instr[12:8];
  assign dec_writer = (dec_opcode <= 4'd7) || (dec_opcode == 4'd13);

  // Operand read with same-cycle writeback bypass; r0 is hardwired to zero.
  always_comb begin
    rn_val = regs_q[dec_rn];
    if (dec_rn == 5'd0) begin
      rn_val = '0;
    end else if (wb_en && (wb_addr == dec_rn)) begin
      rn_val = wb_data;
    end
  end

  always_comb begin
    rm_val = regs_q[dec_rm];
    if (dec_rm == 5'd0) begin
      rm_val = '0;
    end else if (wb_en && (wb_addr == dec_rm)) begin
      rm_val = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_en && (wb_addr != 5'd0)) begin
      regs_q[wb_addr] <= wb_data;
    end
  end

  // A writeback arriving this cycle resolves the pending bit for its register.
  assign wb_onehot = wb_en ? (NREGS'(1) << wb_addr) : '0;
  assign pend_eff  = pend_q & ~wb_onehot;

  assign hazard   = pend_eff[dec_rn] || pend_eff[dec_rm] || (dec_writer && pend_eff[dec_rd]);
  assign in_ready = !flush && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Set for a newly issued writer wins over any clear on the same register.
  always_comb begin
    pend_d = pend_q & ~wb_onehot;
    if (flush && out_valid_q && out_wr_q) begin
      pend_d[out_instr_q[22:18]] = 1'b0;
    end
    if (accept && dec_writer && (dec_rd != 5'd0)) begin
      pend_d[dec_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_wr_q    <= 1'b0;
      out_instr_q <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_wr_q    <= dec_writer;
      out_instr_q <= in_instr;
      in1_q       <= rn_val;
      in2_q       <= rm_val;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_wr      = out_wr_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign alu_cond    = out_instr_q[31:28];
  assign alu_opcode  = out_instr_q[27:24];
  assign alu_s       = out_instr_q[23];
  assign out_rd      = out_instr_q[22:18];
  assign alu_sr_cont = out_instr_q[7:5];
  assign alu_sr_bit  = out_instr_q[4:0];
  assign alu_imm     = out_instr_q[15:0];

endmodule
